heat_column_store: RTL and testbench
====================================

Name: heat_column_store

Overview:
- One instance per display column (64 instances) behind the HPS read/plot sequencer; consumes that sequencer's col_select[x] / row_select / pixel_color request and answers on return_sig[x].
- Holds one column of 8-bit heat pixels in a simple dual-port M10K: write side for the plot handshake, independent read side for the VGA scan-out.
- Gives the sequencer a 4-phase acknowledge so it can step through points without overrunning the column.

Parameters:
- COL_INDEX, 0, column number of this instance; used only in debug/bench checks.
- ROWS, 480, number of valid rows stored.
- ADDR_W, 10, row address width; must satisfy 2^ADDR_W >= ROWS.
- PIX_W, 8, pixel width.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-low reset.
- col_select  in  1  this column's bit of the sequencer's col_select bus; request strobe.
- row_select  in  ADDR_W  target row; held stable while col_select is high.
- pixel_color  in  PIX_W  pixel value; held stable while col_select is high.
- return_sig  out  1  acknowledge to this column's bit of the sequencer's return_sig bus.
- vga_row  in  ADDR_W  row address requested by the VGA scan-out.
- vga_rd  in  1  VGA read strobe.
- vga_pixel  out  PIX_W  read data.
- vga_valid  out  1  high for one cycle when vga_pixel holds the data for a vga_rd issued 2 cycles earlier.
- wr_oob  out  1  sticky: a request arrived with row_select >= ROWS.
- wr_count  out  16  number of accepted requests; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; return_sig=0, vga_valid=0, vga_pixel=0, wr_oob=0, wr_count=0. Memory contents are untouched (see Optional Feature).
- Reset asserted mid-handshake: return_sig drops immediately and the pending write is abandoned. If the write enable was already sampled, that write completes.
- FSM states and transitions:
  - IDLE: if col_select=1 on an edge, latch row_select and pixel_color, then go to WRITE.
  - WRITE (1 cycle): if the latched row < ROWS, we=1 and the M10K is written; otherwise no write and wr_oob<=1. wr_count increments, saturating. Go to ACK.
  - ACK: return_sig=1. Stay while col_select=1. When col_select is sampled 0, go to IDLE; return_sig is 0 from the next cycle.
- Timing: col_select sampled high at edge N. Memory write at edge N+1. return_sig high from edge N+2.
- An out-of-range row is still acknowledged so the sequencer never hangs.
- A new request is accepted only in IDLE. col_select re-rising while in ACK is ignored until it has been seen low.
- col_select dropping before ACK: the latched data is still written. ACK then sees col_select=0 and returns return_sig to 0 one cycle later.
- VGA read side: independent of the FSM; never stalls and never stalls writes.
  - vga_row is registered on vga_rd.
  - The M10K read is registered.
  - Latency is 2 cycles; back-to-back reads sustain 1 per cycle.
  - vga_pixel holds its last value when vga_valid=0.
- VGA row >= ROWS returns 0 with vga_valid=1.
- Read-during-write to the same row returns the old data (M10K default). The new data is visible on a read issued the cycle after the write.

Optional Feature:
- Macro HEAT_COL_CLEAR_EN.
- Defined: after reset deasserts, state CLEAR sweeps rows 0..ROWS-1 writing 0, one row per cycle, then goes to IDLE.
  - During CLEAR: col_select is ignored and return_sig=0. A request held across the end of CLEAR is accepted in IDLE.
  - VGA reads during CLEAR return whatever the memory holds.
- Undefined: no CLEAR state; IDLE is entered directly from reset and memory powers up undefined.

Test Plan:
- After reset, raise col_select with row 5 / pixel 8'hFF, hold until return_sig, then drop -> return_sig high 2 cycles after rise and low 1 cycle after drop; vga_rd row 5 returns 8'hFF with vga_valid 2 cycles later; wr_count=1.
- Two consecutive requests (row 10 = 8'h12, then row 11 = 8'h34) with col_select re-raised 5 cycles after the first drop -> both acknowledged; reads give 8'h12 and 8'h34; wr_count=2.
- Request row 500 (>= ROWS) -> return_sig still asserts; wr_oob=1; no row altered (row 500 mod 512 aliasing not written); VGA read of row 500 returns 0.
- Pull reset low while in ACK -> return_sig=0 asynchronously; wr_oob=0 and wr_count=0; previously written row 5 still reads 8'hFF (macro off).
- Write row 7 = 8'hAA while vga_rd targets row 7 in the same cycle -> old value returned; read issued the next cycle returns 8'hAA.
- With HEAT_COL_CLEAR_EN: col_select held high from reset release -> return_sig stays 0 for 480+ cycles, then the handshake completes; VGA read of any untouched row returns 0.

Source files
------------

// File: rtl/heat_column_store.sv
// One display column of 8-bit heat pixels: 4-phase plot handshake on the write port,
// free-running 2-cycle VGA read port. Optional HEAT_COL_CLEAR_EN zeroes the column after reset.
module heat_column_store #(
    parameter int COL_INDEX = 0,
    parameter int ROWS      = 480,
    parameter int ADDR_W    = 10,
    parameter int PIX_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              col_select,
    input  logic [ADDR_W-1:0] row_select,
    input  logic [PIX_W-1:0]  pixel_color,
    output logic              return_sig,
    input  logic [ADDR_W-1:0] vga_row,
    input  logic              vga_rd,
    output logic [PIX_W-1:0]  vga_pixel,
    output logic              vga_valid,
    output logic              wr_oob,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (DEPTH < ROWS || COL_INDEX < 0) begin : g_bad_cfg
        $error("heat_column_store: ADDR_W too small for ROWS or negative COL_INDEX");
    end

    typedef enum logic [1:0] {IDLE, WRITE, ACK, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              ret_q, ret_d;
    logic              oob_q, oob_d;
    logic [15:0]       cnt_q, cnt_d;
`ifdef HEAT_COL_CLEAR_EN
    logic [ADDR_W-1:0] clr_q, clr_d;
`endif

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [PIX_W-1:0]  wdata;

    logic [PIX_W-1:0]  mem [0:DEPTH-1];
    logic [PIX_W-1:0]  rdata_q;
    logic [1:0]        vld_pipe_q;
    logic              rd_oob_q;
    logic [PIX_W-1:0]  pix_out_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pix_d   = pix_q;
        oob_d   = oob_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        waddr   = row_q;
        wdata   = pix_q;
`ifdef HEAT_COL_CLEAR_EN
        clr_d   = clr_q;
`endif
        case (state_q)
            IDLE: begin
                if (col_select) begin
                    row_d   = row_select;
                    pix_d   = pixel_color;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Out-of-range rows are counted and acknowledged but never written.
                if (32'(row_q) < ROWS) we = 1'b1;
                else                   oob_d = 1'b1;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                state_d = ACK;
            end
            ACK: begin
                if (!col_select) state_d = IDLE;
            end
            CLEAR: begin
`ifdef HEAT_COL_CLEAR_EN
                we    = 1'b1;
                waddr = clr_q;
                wdata = '0;
                clr_d = clr_q + 1'b1;
                if (32'(clr_q) == ROWS - 1) state_d = IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        // Registered ack: rises two edges after the request is sampled, falls on the edge that sees the drop.
        ret_d = (state_q == ACK) && col_select;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
`ifdef HEAT_COL_CLEAR_EN
            state_q <= CLEAR;
            clr_q   <= '0;
`else
            state_q <= IDLE;
`endif
            row_q   <= '0;
            pix_q   <= '0;
            ret_q   <= 1'b0;
            oob_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
`ifdef HEAT_COL_CLEAR_EN
            clr_q   <= clr_d;
`endif
            row_q   <= row_d;
            pix_q   <= pix_d;
            ret_q   <= ret_d;
            oob_q   <= oob_d;
            cnt_q   <= cnt_d;
        end
    end

    // M10K array: no reset, read-during-write on the same edge yields the old word.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (vga_rd) rdata_q <= mem[vga_row];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe_q <= '0;
            rd_oob_q   <= 1'b0;
            pix_out_q  <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], vga_rd};
            if (vga_rd) rd_oob_q <= (32'(vga_row) >= ROWS);
            if (vld_pipe_q[0]) pix_out_q <= rd_oob_q ? '0 : rdata_q;
        end
    end

    assign return_sig = ret_q;
    assign wr_oob     = oob_q;
    assign wr_count   = cnt_q;
    assign vga_valid  = vld_pipe_q[1];
    assign vga_pixel  = pix_out_q;

endmodule

// File: tb/tb_heat_column_store.sv
// Directed bench for heat_column_store: handshake timing checked inline, VGA reads via a scoreboard queue.
module tb_heat_column_store;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       col_select = 1'b0;
    logic [9:0] row_select = '0;
    logic [7:0] pixel_color = '0;
    logic       return_sig;
    logic [9:0] vga_row = '0;
    logic       vga_rd = 1'b0;
    logic [7:0] vga_pixel;
    logic       vga_valid;
    logic       wr_oob;
    logic [15:0] wr_count;

    heat_column_store #(.COL_INDEX(0), .ROWS(480), .ADDR_W(10), .PIX_W(8)) dut (
        .clock(clock), .reset(reset), .col_select(col_select), .row_select(row_select),
        .pixel_color(pixel_color), .return_sig(return_sig), .vga_row(vga_row), .vga_rd(vga_rd),
        .vga_pixel(vga_pixel), .vga_valid(vga_valid), .wr_oob(wr_oob), .wr_count(wr_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         t;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && vga_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vga_unexpected: got %0h expected no valid", vga_pixel);
            end else begin
                mon_e = sb.pop_front();
                chk("vga_pixel", vga_pixel, mon_e.data);
                chk("vga_latency", cyc - mon_e.t, 2);
            end
        end
    end

    // Call on a negedge; the read is sampled on the following posedge.
    task automatic issue(input logic [9:0] r, input logic [7:0] e);
        exp_t x;
        vga_rd  = 1'b1;
        vga_row = r;
        x.data  = e;
        x.t     = cyc;
        sb.push_back(x);
    endtask

    task automatic rd(input logic [9:0] r, input logic [7:0] e);
        @(negedge clock);
        issue(r, e);
        @(negedge clock);
        vga_rd = 1'b0;
    endtask

    task automatic req(input logic [9:0] r, input logic [7:0] p);
        int n;
        n = 0;
        @(negedge clock);
        row_select = r; pixel_color = p; col_select = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!return_sig && n < 20);
        chk("ack_latency", n, 3);
        col_select = 1'b0;
        @(negedge clock);
        chk("ack_release", return_sig, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [7:0] exp5;
        repeat (3) @(negedge clock);
        chk("rst_return", return_sig, 0);
        chk("rst_valid", vga_valid, 0);
        chk("rst_pixel", vga_pixel, 0);
        chk("rst_oob", wr_oob, 0);
        chk("rst_count", wr_count, 0);

`ifdef HEAT_COL_CLEAR_EN
        // Request held across the whole clear sweep.
        row_select = 10'd3; pixel_color = 8'h5A; col_select = 1'b1;
        reset = 1'b1;
        n = 0;
        while (!return_sig && n < 700) begin
            @(negedge clock);
            n++;
        end
        chk("clear_hold", (n >= 480 && n < 700), 1);
        col_select = 1'b0;
        @(negedge clock);
        chk("clear_release", return_sig, 0);
        rd(10'd3, 8'h5A);
        rd(10'd300, 8'h00);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (490) @(negedge clock);
`else
        reset = 1'b1;
`endif

        req(10'd5, 8'hFF);
        rd(10'd5, 8'hFF);
        chk("count_1", wr_count, 1);

        req(10'd10, 8'h12);
        repeat (5) @(negedge clock);
        req(10'd11, 8'h34);
        @(negedge clock); issue(10'd10, 8'h12);
        @(negedge clock); issue(10'd11, 8'h34);
        @(negedge clock); issue(10'd5, 8'hFF);
        @(negedge clock); vga_rd = 1'b0;
        chk("count_3", wr_count, 3);
        chk("oob_clear", wr_oob, 0);

        req(10'd500, 8'h77);
        chk("oob_set", wr_oob, 1);
        chk("count_4", wr_count, 4);
        rd(10'd500, 8'h00);
        rd(10'd10, 8'h12);

        // Early drop: one-cycle strobe is still written and never acknowledged.
        @(negedge clock);
        row_select = 10'd12; pixel_color = 8'h56; col_select = 1'b1;
        @(negedge clock);
        col_select = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clock);
            if (return_sig) n++;
        end
        chk("short_no_ack", n, 0);
        rd(10'd12, 8'h56);
        chk("count_5", wr_count, 5);

        // Read-during-write on row 7.
        req(10'd7, 8'h11);
        @(negedge clock);
        row_select = 10'd7; pixel_color = 8'hAA; col_select = 1'b1;
        @(negedge clock); issue(10'd7, 8'h11);
        @(negedge clock); issue(10'd7, 8'hAA);
        @(negedge clock); vga_rd = 1'b0;
        chk("rdw_ack", return_sig, 1);
        col_select = 1'b0;
        @(negedge clock);
        chk("rdw_release", return_sig, 0);
        chk("count_7", wr_count, 7);

        // Reset while in ACK.
        @(negedge clock);
        row_select = 10'd9; pixel_color = 8'h99; col_select = 1'b1;
        n = 0;
        while (!return_sig && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("pre_reset_ack", return_sig, 1);
        reset = 1'b0;
        #1;
        chk("async_return", return_sig, 0);
        chk("async_oob", wr_oob, 0);
        chk("async_count", wr_count, 0);
        col_select = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
`ifdef HEAT_COL_CLEAR_EN
        repeat (490) @(negedge clock);
        exp5 = 8'h00;
`else
        exp5 = 8'hFF;
`endif
        rd(10'd5, exp5);

        repeat (5) @(negedge clock);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
